secure_log_scheduler: RTL and testbench



---
 rtl/secure_log_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_secure_log_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/secure_log_scheduler.sv
// rtl/secure_log_scheduler.sv - round-robin owner of a shared secure logger session engine
// Optional WAIT watchdog enabled by defining LOG_TIMEOUT_EN.
module secure_log_scheduler #(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     power_fail,
  input  logic                     log_done,
  input  logic                     log_fail,
  output logic                     log_start,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     busy,
  output logic [N_REQ-1:0]         served,
  output logic [N_REQ-1:0]         err_flag,
  output logic                     timeout,
  output logic [7:0]               session_cnt
);
  localparam int SW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_RETRY < 0 || MAX_RETRY > 7 || TIMEOUT < 2) begin : g_bad_param
    $error("secure_log_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RETRY, S_HALT} state_t;

  state_t           r_state, w_state_nx;
  logic [N_REQ-1:0] r_grant, w_grant_nx, r_served, w_served_nx, r_err, w_err_nx;
  logic [SW-1:0]    r_sel, w_sel_nx, r_rr, w_rr_nx, w_pick, w_sel_inc;
  logic [2:0]       r_retry, w_retry_nx;
  logic [7:0]       r_cnt, w_cnt_nx;
  logic             r_start, w_start_nx, r_busy;
  logic [N_REQ-1:0] w_masked;
  logic             w_wd_exp;

  // First set bit at or above p, wrapping; rotating a doubled copy keeps it valid for non-power-of-two N_REQ.
  function automatic logic [SW-1:0] f_pick(input logic [N_REQ-1:0] m, input logic [SW-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic               found;
    int                 k;
    int                 sum;
    dbl   = {m, m} >> p;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && dbl[0]) begin
        k     = i;
        found = 1'b1;
      end
      dbl = dbl >> 1;
    end
    sum = int'(p) + k;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return SW'(sum);
  endfunction

  assign w_masked  = req & ~r_err;
  assign w_pick    = f_pick(w_masked, r_rr);
  assign w_sel_inc = (r_sel == SW'(N_REQ - 1)) ? '0 : r_sel + 1'b1;

`ifdef LOG_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT);
  logic [WW-1:0] r_wd;
  logic          r_timeout;

  assign w_wd_exp = (r_wd == WW'(TIMEOUT - 1)) && !log_done && !log_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == S_WAIT) && w_wd_exp && !power_fail;
      if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
      else                   r_wd <= '0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_exp = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_grant_nx  = r_grant;
    w_sel_nx    = r_sel;
    w_rr_nx     = r_rr;
    w_retry_nx  = r_retry;
    w_err_nx    = r_err;
    w_cnt_nx    = r_cnt;
    w_served_nx = '0;
    w_start_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_masked) begin
          w_grant_nx = N_REQ'(1) << w_pick;
          w_sel_nx   = w_pick;
          w_retry_nx = '0;
          w_start_nx = 1'b1;
          w_state_nx = S_START;
        end
      end
      S_START: w_state_nx = S_WAIT;
      S_WAIT: begin
        if (log_fail || w_wd_exp) begin
          if (r_retry < 3'(MAX_RETRY)) begin
            w_retry_nx = r_retry + 3'd1;
            w_state_nx = S_RETRY;
          end else begin
            w_err_nx   = r_err | r_grant;
            w_grant_nx = '0;
            w_rr_nx    = w_sel_inc;
            w_state_nx = S_IDLE;
          end
        end else if (log_done) begin
          w_served_nx = r_grant;
          w_cnt_nx    = r_cnt + 8'd1;
          w_grant_nx  = '0;
          w_rr_nx     = w_sel_inc;
          w_state_nx  = S_IDLE;
        end
      end
      S_RETRY: begin
        w_start_nx = 1'b1;
        w_state_nx = S_START;
      end
      S_HALT: if (!power_fail) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // Power loss discards the in-flight session without touching error or success bookkeeping.
    if (power_fail) begin
      w_state_nx  = S_HALT;
      w_grant_nx  = '0;
      w_start_nx  = 1'b0;
      w_served_nx = '0;
      w_err_nx    = r_err;
      w_cnt_nx    = r_cnt;
      w_rr_nx     = r_rr;
      w_retry_nx  = r_retry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_sel    <= '0;
      r_rr     <= '0;
      r_retry  <= '0;
      r_err    <= '0;
      r_cnt    <= '0;
      r_served <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_grant  <= w_grant_nx;
      r_sel    <= w_sel_nx;
      r_rr     <= w_rr_nx;
      r_retry  <= w_retry_nx;
      r_err    <= w_err_nx;
      r_cnt    <= w_cnt_nx;
      r_served <= w_served_nx;
      r_start  <= w_start_nx;
      r_busy   <= (w_state_nx != S_IDLE);
    end
  end

  assign log_start   = r_start;
  assign grant       = r_grant;
  assign sel         = r_sel;
  assign busy        = r_busy;
  assign served      = r_served;
  assign err_flag    = r_err;
  assign session_cnt = r_cnt;
endmodule

// File: tb/tb_secure_log_scheduler.sv
// tb/tb_secure_log_scheduler.sv - directed-vector bench for secure_log_scheduler
// Expected values are hand-derived for N_REQ=4, MAX_RETRY=2, TIMEOUT=8.
module tb_secure_log_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       power_fail, log_done, log_fail;
  logic       log_start, busy, timeout;
  logic [3:0] grant, served, err_flag;
  logic [1:0] sel;
  logic [7:0] session_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  secure_log_scheduler #(.N_REQ(4), .MAX_RETRY(2), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .power_fail(power_fail),
    .log_done(log_done), .log_fail(log_fail), .log_start(log_start),
    .grant(grant), .sel(sel), .busy(busy), .served(served),
    .err_flag(err_flag), .timeout(timeout), .session_cnt(session_cnt)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; power_fail = 1'b0; log_done = 1'b0; log_fail = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic       ls_exp [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int         pulses;
  logic       to_seen;

  initial begin
    do_reset();
    expect_eq("rst_grant", grant, 4'b0000);
    expect_eq("rst_sel", sel, 2'd0);
    expect_eq("rst_start", log_start, 1'b0);
    expect_eq("rst_busy", busy, 1'b0);
    expect_eq("rst_served", served, 4'b0000);
    expect_eq("rst_err", err_flag, 4'b0000);
    expect_eq("rst_cnt", session_cnt, 8'd0);
    expect_eq("rst_timeout", timeout, 1'b0);

    // Single requester
    req = 4'b0100;
    step();
    expect_eq("single_grant", grant, 4'b0100);
    expect_eq("single_sel", sel, 2'd2);
    expect_eq("single_start", log_start, 1'b1);
    expect_eq("single_busy", busy, 1'b1);
    req = 4'b0000;
    step();
    expect_eq("single_start_drop", log_start, 1'b0);
    step(); step(); step();
    log_done = 1'b1;
    step();
    log_done = 1'b0;
    expect_eq("single_served", served, 4'b0100);
    expect_eq("single_cnt", session_cnt, 8'd1);
    expect_eq("single_idle", busy, 1'b0);
    step();
    expect_eq("single_served_pulse", served, 4'b0000);

    // Round robin with all sources requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_eq("rr_grant", grant, rr_exp[i]);
      expect_eq("rr_served_clear", served, 4'b0000);
      step(); step(); step();
      log_done = 1'b1;
      step();
      log_done = 1'b0;
      expect_eq("rr_served", served, rr_exp[i]);
    end
    expect_eq("rr_cnt", session_cnt, 8'd5);
    req = 4'b0000;

    // Retry then error, errored source skipped afterwards
    do_reset();
    req = 4'b0001;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 1) log_fail = 1'b1;
      expect_eq("retry_start_seq", log_start, ls_exp[i]);
      if (log_start) pulses++;
    end
    log_fail = 1'b0;
    expect_eq("retry_pulses", pulses, 3);
    expect_eq("retry_err", err_flag, 4'b0001);
    expect_eq("retry_grant_clr", grant, 4'b0000);
    req = 4'b0011;
    step();
    expect_eq("skip_err_grant", grant, 4'b0010);
    step();
    log_done = 1'b1;
    step();
    log_done = 1'b0;
    expect_eq("skip_err_served", served, 4'b0010);
    req = 4'b0001;
    step();
    expect_eq("masked_no_grant", grant, 4'b0000);
    expect_eq("masked_idle", busy, 1'b0);
    req = 4'b0000;

    // Done and fail together count as a fail
    do_reset();
    req = 4'b0001;
    step(); step();
    log_done = 1'b1; log_fail = 1'b1;
    step();
    log_done = 1'b0; log_fail = 1'b0;
    expect_eq("both_no_served", served, 4'b0000);
    expect_eq("both_cnt", session_cnt, 8'd0);
    expect_eq("both_busy", busy, 1'b1);
    expect_eq("both_grant_held", grant, 4'b0001);
    step();
    expect_eq("both_restart", log_start, 1'b1);
    step();
    log_fail = 1'b1;
    step();
    expect_eq("both_second_fail_err", err_flag, 4'b0000);
    step(); step(); step();
    log_fail = 1'b0;
    expect_eq("both_third_fail_err", err_flag, 4'b0001);
    req = 4'b0000;

    // Power fail mid-WAIT
    do_reset();
    req = 4'b0010;
    step(); step(); step();
    power_fail = 1'b1;
    log_done   = 1'b1;
    step();
    expect_eq("pf_grant", grant, 4'b0000);
    expect_eq("pf_busy", busy, 1'b1);
    step(); step(); step();
    expect_eq("pf_hold_busy", busy, 1'b1);
    expect_eq("pf_hold_start", log_start, 1'b0);
    power_fail = 1'b0;
    log_done   = 1'b0;
    step();
    expect_eq("pf_release_idle", busy, 1'b0);
    expect_eq("pf_no_served", served, 4'b0000);
    expect_eq("pf_no_err", err_flag, 4'b0000);
    expect_eq("pf_no_cnt", session_cnt, 8'd0);
    step();
    expect_eq("pf_regrant", grant, 4'b0010);
    expect_eq("pf_restart", log_start, 1'b1);
    step();
    log_done = 1'b1;
    step();
    log_done = 1'b0;
    expect_eq("pf_served", served, 4'b0010);
    expect_eq("pf_cnt", session_cnt, 8'd1);
    req = 4'b0000;

    // Silent logger
    do_reset();
    req = 4'b0001;
    step(); step();
`ifdef LOG_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      step();
      expect_eq("wd_timeout", timeout, (i == 7) ? 1'b1 : 1'b0);
    end
    expect_eq("wd_no_err", err_flag, 4'b0000);
    step();
    expect_eq("wd_pulse_end", timeout, 1'b0);
    expect_eq("wd_retry_start", log_start, 1'b1);
`else
    to_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      to_seen = to_seen | timeout;
    end
    expect_eq("nowd_timeout", to_seen, 1'b0);
    expect_eq("nowd_busy", busy, 1'b1);
    expect_eq("nowd_grant", grant, 4'b0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
